// File: rtl/bmu_pkg.sv
// bmu_pkg: opcode encoding shared by the bit-manipulation ALU,
// its pipeline wrapper and anything that issues ops to them.
package bmu_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    BMU_ADD   = 5'd0,
    BMU_SUB   = 5'd1,
    BMU_AND   = 5'd2,
    BMU_ANDN  = 5'd3,
    BMU_XOR   = 5'd4,
    BMU_SLL   = 5'd5,
    BMU_SRA   = 5'd6,
    BMU_ROL   = 5'd7,
    BMU_BEXT  = 5'd8,
    BMU_SLT   = 5'd9,
    BMU_SLTU  = 5'd10,
    BMU_MIN   = 5'd11,
    BMU_MINU  = 5'd12,
    BMU_CLZ   = 5'd13,
    BMU_CPOP  = 5'd14,
    BMU_SEXTH = 5'd15,
    BMU_ZEXTH = 5'd16
  } bmu_op_e;

endpackage

// File: rtl/bmu_alu.sv
// bmu_alu: combinational ALU / bit-manipulation datapath.
// Illegal opcodes yield a zero result with error set.
module bmu_alu
  import bmu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            error_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0]   sh;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     dif;
  logic [2*XLEN-1:0] rot;
  logic [XLEN-1:0]   clz;
  logic [XLEN-1:0]   cpop;
  logic              slt;
  logic              sltu;

  assign sh   = b_i[SH_W-1:0];
  assign sum  = {a_i[XLEN-1], a_i} + {b_i[XLEN-1], b_i};
  assign dif  = {a_i[XLEN-1], a_i} - {b_i[XLEN-1], b_i};
  // rotate = upper half of the doubled word shifted left
  assign rot  = {a_i, a_i} << sh;
  assign slt  = $signed(a_i) < $signed(b_i);
  assign sltu = a_i < b_i;

  always_comb begin
    clz = XLEN'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (a_i[i]) clz = XLEN'(XLEN - 1 - i);
    end
  end

  always_comb begin
    cpop = '0;
    for (int i = 0; i < XLEN; i++) begin
      cpop = cpop + XLEN'(a_i[i]);
    end
  end

  always_comb begin
    result_o = '0;
    error_o  = 1'b0;
    case (op_i)
      BMU_ADD: begin
        result_o = sum[XLEN-1:0];
        error_o  = sum[XLEN] ^ sum[XLEN-1];
      end
      BMU_SUB: begin
        result_o = dif[XLEN-1:0];
        error_o  = dif[XLEN] ^ dif[XLEN-1];
      end
      BMU_AND:   result_o = a_i & b_i;
      BMU_ANDN:  result_o = a_i & ~b_i;
      BMU_XOR:   result_o = a_i ^ b_i;
      BMU_SLL:   result_o = a_i << sh;
      BMU_SRA:   result_o = $signed(a_i) >>> sh;
      BMU_ROL:   result_o = rot[2*XLEN-1:XLEN];
      BMU_BEXT:  result_o = XLEN'(a_i[sh]);
      BMU_SLT:   result_o = XLEN'(slt);
      BMU_SLTU:  result_o = XLEN'(sltu);
      BMU_MIN:   result_o = slt ? a_i : b_i;
      BMU_MINU:  result_o = sltu ? a_i : b_i;
      BMU_CLZ:   result_o = clz;
      BMU_CPOP:  result_o = cpop;
      BMU_SEXTH: result_o = XLEN'($signed(a_i[15:0]));
      BMU_ZEXTH: result_o = XLEN'(a_i[15:0]);
      default:   error_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/bmu_pipe.sv
// bmu_pipe: two-stage valid/ready pipeline around bmu_alu with
// tag sideband, flush and a saturating errored-result counter.
module bmu_pipe
  import bmu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_error,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_cnt_clr
);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic             error;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_adv, s2_adv;
  logic             accept, handoff;
  logic [XLEN-1:0]  alu_res;
  logic             alu_err;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  // rst_l keeps in_ready low while reset is held
  assign in_ready = s1_adv && !flush && rst_l;
  assign accept   = in_valid && in_ready;
  assign handoff  = s2_valid_q && out_ready;

  bmu_alu #(.XLEN(XLEN)) u_alu (
    .op_i     (s1_q.op),
    .a_i      (s1_q.a),
    .b_i      (s1_q.b),
    .result_o (alu_res),
    .error_o  (alu_err)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_d = '{op: in_op, a: in_a, b: in_b, tag: in_tag};
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = '{result: alu_res, error: alu_err, tag: s1_q.tag};
      end
    end
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_cnt_clr) begin
      cnt_d = '0;
    end else if (handoff && s2_q.error && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_q.result;
  assign out_error  = s2_q.error;
  assign out_tag    = s2_q.tag;
  assign err_cnt    = cnt_q;

endmodule
